// File: rtl/adc_store_pkg.sv
// adc_store_pkg: shared types and constants for the ADC sample store.
//   state_e      - capture FSM states
//   NUM_SLOTS    - channel slots (8 per ADC, two ADCs)
//   VALUE_W      - ADC result width
//   RD_W         - read data width, packed {new, ovr, 2'b00, value}
//   ACC_W        - averaging accumulator width (4 x 12-bit samples)
package adc_store_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    WR_A     = 2'd2,
    WR_B     = 2'd3
  } state_e;

  localparam int unsigned NUM_SLOTS  = 16;
  localparam int unsigned VALUE_W    = 12;
  localparam int unsigned RD_W       = 16;
  localparam int unsigned ACC_W      = 14;

  localparam int unsigned RD_NEW_BIT = 15;
  localparam int unsigned RD_OVR_BIT = 14;
  localparam int unsigned RD_VAL_MSB = VALUE_W - 1;

endpackage

// File: rtl/pld_sync2.sv
// pld_sync2: single-bit synchroniser of parameterised depth.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (chain clears to 0)
//   d     - asynchronous input
//   q     - synchronised output, STAGES cycles of latency
module pld_sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adc_sample_store.sv
// adc_sample_store: captures ADC A/B results per frame from the PLD serial
// stream and holds the latest value per channel for host reads.
//   CLK_24MHZ_FPGA / nSYSPOR     - clock, async active-low reset
//   SYNC, PLDRESETn              - PLDCLK-domain controls, synchronised here
//   PGOOD, ADCSEL, ADC_DOUTA/B   - quasi-static frame data, sampled directly
//   RD_EN, RD_ADDR -> RD_DATA, RD_VALID - registered slot read, clears flags
//   NEWFLAGS, FRAME_CNT, SAMPLE_STB     - status
// Optional macro ADC_AVERAGE_EN: publish the mean of every 4 samples per slot.
module adc_sample_store
  import adc_store_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DISCARD_FRAMES = 1
) (
  input  logic                 CLK_24MHZ_FPGA,
  input  logic                 nSYSPOR,
  input  logic                 SYNC,
  input  logic                 PLDRESETn,
  input  logic                 PGOOD,
  input  logic [2:0]           ADCSEL,
  input  logic [VALUE_W-1:0]   ADC_DOUTA,
  input  logic [VALUE_W-1:0]   ADC_DOUTB,
  input  logic                 RD_EN,
  input  logic [3:0]           RD_ADDR,
  output logic [RD_W-1:0]      RD_DATA,
  output logic                 RD_VALID,
  output logic [NUM_SLOTS-1:0] NEWFLAGS,
  output logic [15:0]          FRAME_CNT,
  output logic                 SAMPLE_STB
);

  localparam int DW = (DISCARD_FRAMES < 1) ? 1 : $clog2(DISCARD_FRAMES + 1);
  localparam logic [DW-1:0] DISC_INIT = DW'(DISCARD_FRAMES);

  logic sync_s, pld_s, sync_prev_q, frame_evt;

  pld_sync2 #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(CLK_24MHZ_FPGA), .rst_n(nSYSPOR), .d(SYNC), .q(sync_s)
  );
  pld_sync2 #(.STAGES(SYNC_STAGES)) u_sync_pldrst (
    .clk(CLK_24MHZ_FPGA), .rst_n(nSYSPOR), .d(PLDRESETn), .q(pld_s)
  );

  assign frame_evt = sync_s & ~sync_prev_q;

  state_e               state_q, state_d;
  logic [DW-1:0]        disc_q, disc_d;
  logic [2:0]           sel_q, sel_d;
  logic [VALUE_W-1:0]   a_q, a_d, b_q, b_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 stb_q, stb_d;
  logic                 wr_en, wr_adc;

  logic [VALUE_W-1:0]   val_q [NUM_SLOTS];
  logic [VALUE_W-1:0]   val_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] new_q, new_d, ovr_q, ovr_d;
  logic [RD_W-1:0]      rd_data_q, rd_data_d;
  logic                 rd_valid_q;

  logic [3:0]           wr_addr;
  logic [VALUE_W-1:0]   sample, pub_val;
  logic                 publish;

  always_comb begin
    state_d     = state_q;
    disc_d      = disc_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    frame_cnt_d = frame_cnt_q;
    stb_d       = 1'b0;
    wr_en       = 1'b0;
    wr_adc      = 1'b0;
    unique case (state_q)
      WAIT_LOW: if (!sync_s) state_d = ARMED;
      ARMED: begin
        if (frame_evt) begin
          sel_d = ADCSEL;
          a_d   = ADC_DOUTA;
          b_d   = ADC_DOUTB;
          if (pld_s && PGOOD && disc_q == '0) state_d = WR_A;
          else if (pld_s && disc_q != '0)     disc_d  = disc_q - DW'(1);
        end
      end
      WR_A: begin
        wr_en   = 1'b1;
        state_d = WR_B;
      end
      WR_B: begin
        wr_en       = 1'b1;
        wr_adc      = 1'b1;
        stb_d       = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ARMED;
      end
      default: state_d = WAIT_LOW;
    endcase
    // Stream back in static/ID phase: abandon any frame in flight.
    if (!pld_s) begin
      state_d     = WAIT_LOW;
      disc_d      = DISC_INIT;
      wr_en       = 1'b0;
      stb_d       = 1'b0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  assign wr_addr = {wr_adc, sel_q};
  assign sample  = wr_adc ? b_q : a_q;

`ifdef ADC_AVERAGE_EN
  logic [ACC_W-1:0] acc_q [NUM_SLOTS];
  logic [ACC_W-1:0] acc_d [NUM_SLOTS];
  logic [1:0]       cnt_q [NUM_SLOTS];
  logic [1:0]       cnt_d [NUM_SLOTS];
  logic [ACC_W-1:0] sum;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    publish = 1'b0;
    pub_val = sample;
    sum     = '0;
    if (wr_en) begin
      sum = acc_q[wr_addr] + ACC_W'(sample);
      if (cnt_q[wr_addr] == 2'd3) begin
        publish          = 1'b1;
        pub_val          = VALUE_W'(sum >> 2);
        acc_d[wr_addr]   = '0;
        cnt_d[wr_addr]   = '0;
      end else begin
        acc_d[wr_addr]   = sum;
        cnt_d[wr_addr]   = cnt_q[wr_addr] + 2'd1;
      end
    end
    if (!pld_s) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK_24MHZ_FPGA or negedge nSYSPOR) begin
    if (!nSYSPOR) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    publish = wr_en;
    pub_val = sample;
  end
`endif

  // Read samples pre-write contents; a same-slot write then re-sets the flags.
  always_comb begin
    val_d     = val_q;
    new_d     = new_q;
    ovr_d     = ovr_q;
    rd_data_d = rd_data_q;
    if (RD_EN) begin
      rd_data_d                   = '0;
      rd_data_d[RD_NEW_BIT]       = new_q[RD_ADDR];
      rd_data_d[RD_OVR_BIT]       = ovr_q[RD_ADDR];
      rd_data_d[RD_VAL_MSB:0]     = val_q[RD_ADDR];
      new_d[RD_ADDR]              = 1'b0;
      ovr_d[RD_ADDR]              = 1'b0;
    end
    if (publish) begin
      val_d[wr_addr] = pub_val;
      ovr_d[wr_addr] = ovr_q[wr_addr] | new_q[wr_addr];
      new_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK_24MHZ_FPGA or negedge nSYSPOR) begin
    if (!nSYSPOR) begin
      state_q     <= WAIT_LOW;
      disc_q      <= DISC_INIT;
      sync_prev_q <= 1'b0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      frame_cnt_q <= '0;
      stb_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) val_q[i] <= '0;
      new_q       <= '0;
      ovr_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      disc_q      <= disc_d;
      sync_prev_q <= sync_s;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      frame_cnt_q <= frame_cnt_d;
      stb_q       <= stb_d;
      val_q       <= val_d;
      new_q       <= new_d;
      ovr_q       <= ovr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= RD_EN;
    end
  end

  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign NEWFLAGS   = new_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign SAMPLE_STB = stb_q;

endmodule

// File: tb/tb_adc_sample_store.sv
`timescale 1ns/1ps
module tb_adc_sample_store;

  logic        clk = 1'b0;
  logic        nSYSPOR, SYNC, PLDRESETn, PGOOD, RD_EN, RD_VALID, SAMPLE_STB;
  logic [2:0]  ADCSEL;
  logic [11:0] ADC_DOUTA, ADC_DOUTB;
  logic [3:0]  RD_ADDR;
  logic [15:0] RD_DATA, NEWFLAGS, FRAME_CNT;

  int checks   = 0;
  int failures = 0;
  int stb_seen = 0;
  int stb_before;

  always #21 clk = ~clk;

  adc_sample_store #(.SYNC_STAGES(2), .DISCARD_FRAMES(1)) dut (
    .CLK_24MHZ_FPGA(clk), .nSYSPOR(nSYSPOR), .SYNC(SYNC), .PLDRESETn(PLDRESETn),
    .PGOOD(PGOOD), .ADCSEL(ADCSEL), .ADC_DOUTA(ADC_DOUTA), .ADC_DOUTB(ADC_DOUTB),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .NEWFLAGS(NEWFLAGS), .FRAME_CNT(FRAME_CNT), .SAMPLE_STB(SAMPLE_STB)
  );

  always @(negedge clk) if (nSYSPOR && SAMPLE_STB) stb_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [2:0] sel, input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    ADCSEL = sel; ADC_DOUTA = a; ADC_DOUTB = b;
    repeat (8) @(negedge clk);
    SYNC = 1'b1;
    repeat (50) @(negedge clk);
    SYNC = 1'b0;
    repeat (50) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    @(negedge clk);
    RD_EN = 1'b1; RD_ADDR = addr;
    @(negedge clk);
    RD_EN = 1'b0;
    check_eq({tag, "_valid"}, 32'(RD_VALID), 32'd1);
    check_eq(tag, 32'(RD_DATA), 32'(exp));
  endtask

  initial begin
    nSYSPOR = 1'b0; SYNC = 1'b0; PLDRESETn = 1'b0; PGOOD = 1'b0; RD_EN = 1'b0;
    ADCSEL = '0; ADC_DOUTA = '0; ADC_DOUTB = '0; RD_ADDR = '0;
    repeat (5) @(negedge clk);
    check_eq("rst_rd_data",  32'(RD_DATA),    32'h0);
    check_eq("rst_rd_valid", 32'(RD_VALID),   32'h0);
    check_eq("rst_stb",      32'(SAMPLE_STB), 32'h0);
    check_eq("rst_frame_cnt",32'(FRAME_CNT),  32'h0);
    check_eq("rst_newflags", 32'(NEWFLAGS),   32'h0);
    nSYSPOR = 1'b1;
    repeat (3) @(negedge clk);
    PLDRESETn = 1'b1; PGOOD = 1'b1;
    repeat (10) @(negedge clk);

`ifndef ADC_AVERAGE_EN
    // First frame after PLDRESETn rises is dropped.
    frame(3'd3, 12'h5A5, 12'h0F0);
    check_eq("discard_newflags", 32'(NEWFLAGS),  32'h0);
    check_eq("discard_frame_cnt",32'(FRAME_CNT), 32'd0);
    frame(3'd3, 12'h5A5, 12'h0F0);
    check_eq("f1_newflags",  32'(NEWFLAGS),  32'h0808);
    check_eq("f1_frame_cnt", 32'(FRAME_CNT), 32'd1);
    check_eq("f1_stb_pulses",32'(stb_seen),  32'd1);
    rd(4'd3, 16'h85A5, "rd_a3");
    check_eq("rd_a3_clears", 32'(NEWFLAGS),  32'h0800);
    rd(4'd11, 16'h80F0, "rd_b3");
    check_eq("rd_b3_clears", 32'(NEWFLAGS),  32'h0000);

    // Overrun: two frames without a read.
    frame(3'd1, 12'h123, 12'h456);
    frame(3'd1, 12'h124, 12'h457);
    check_eq("ovr_frame_cnt", 32'(FRAME_CNT), 32'd3);
    rd(4'd1, 16'hC124, "rd_ovr_a1");
    rd(4'd1, 16'h0124, "rd_ovr_a1_again");
    check_eq("ovr_newflags", 32'(NEWFLAGS), 32'h0200);
    rd(4'd9, 16'hC457, "rd_ovr_b1");

    // PGOOD low: frame ignored.
    stb_before = stb_seen;
    PGOOD = 1'b0;
    frame(3'd1, 12'hFFF, 12'hFFF);
    PGOOD = 1'b1;
    check_eq("pgood_newflags",  32'(NEWFLAGS),  32'h0);
    check_eq("pgood_frame_cnt", 32'(FRAME_CNT), 32'd3);
    check_eq("pgood_stb",       32'(stb_seen),  32'(stb_before));
    rd(4'd1, 16'h0124, "pgood_rd_a1");

    // PLDRESETn low mid-stream: data kept, first later frame dropped.
    @(negedge clk); PLDRESETn = 1'b0;
    repeat (20) @(negedge clk); PLDRESETn = 1'b1;
    repeat (10) @(negedge clk);
    rd(4'd3, 16'h05A5, "pldrst_kept_a3");
    frame(3'd4, 12'h444, 12'h888);
    check_eq("pldrst_discard_nf",  32'(NEWFLAGS),  32'h0);
    check_eq("pldrst_discard_cnt", 32'(FRAME_CNT), 32'd3);
    frame(3'd4, 12'h444, 12'h888);
    check_eq("pldrst_accept_nf",  32'(NEWFLAGS),  32'h1010);
    check_eq("pldrst_accept_cnt", 32'(FRAME_CNT), 32'd4);
    rd(4'd4,  16'h8444, "rd_a4");
    rd(4'd12, 16'h8888, "rd_b4");

    // Read/write collision on slot 8 in the WR_B cycle.
    frame(3'd0, 12'h010, 12'h111);
    rd(4'd8, 16'h8111, "rd_b0");
    rd(4'd0, 16'h8010, "rd_a0");
    @(negedge clk);
    ADCSEL = 3'd0; ADC_DOUTA = 12'h020; ADC_DOUTB = 12'h222;
    repeat (8) @(negedge clk);
    SYNC = 1'b1;
    // Edges 1-2 synchronise, 3 latches, 4 writes A; WR_B spans edges 4-5.
    repeat (4) @(posedge clk);
    @(negedge clk); RD_EN = 1'b1; RD_ADDR = 4'd8;
    @(negedge clk); RD_EN = 1'b0;
    check_eq("coll_rd_old",   32'(RD_DATA),     32'h0111);
    check_eq("coll_newflag8", 32'(NEWFLAGS[8]), 32'd1);
    check_eq("coll_stb",      32'(SAMPLE_STB),  32'd1);
    repeat (50) @(negedge clk); SYNC = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("coll_frame_cnt", 32'(FRAME_CNT), 32'd6);
    rd(4'd8, 16'h8222, "coll_rd_new");
    rd(4'd0, 16'h8020, "coll_rd_a0");
`else
    frame(3'd2, 12'd0, 12'd0);
    check_eq("avg_discard_cnt", 32'(FRAME_CNT), 32'd0);
    frame(3'd2, 12'd100, 12'd10);
    check_eq("avg_s1_nf", 32'(NEWFLAGS), 32'h0);
    frame(3'd2, 12'd200, 12'd20);
    check_eq("avg_s2_nf", 32'(NEWFLAGS), 32'h0);
    frame(3'd2, 12'd300, 12'd30);
    check_eq("avg_s3_nf",  32'(NEWFLAGS),  32'h0);
    check_eq("avg_s3_cnt", 32'(FRAME_CNT), 32'd3);
    rd(4'd2, 16'h0000, "avg_rd_a2_pre");
    frame(3'd2, 12'd400, 12'd40);
    check_eq("avg_s4_nf",  32'(NEWFLAGS),  32'h0404);
    check_eq("avg_s4_cnt", 32'(FRAME_CNT), 32'd4);
    check_eq("avg_stb",    32'(stb_seen),  32'd4);
    rd(4'd2,  16'h80FA, "avg_rd_a2");
    rd(4'd10, 16'h8019, "avg_rd_b2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sample_store.md
# adc_sample_store

Captures ADC conversion results delivered over the PLD serial stream and keeps the latest value per ADC channel for the host register interface. One slot is kept for each of 16 channels, each marked with a new flag and an overrun flag. The block sits downstream of the serial stream deserialiser. It runs on the 24 MHz FPGA clock and consumes `SYNC`, `ADCSEL`, `ADC_DOUTA`/`ADC_DOUTB`, `PGOOD` and `PLDRESETn`, which all come from the slower PLDCLK domain.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth applied to `SYNC` and `PLDRESETn`; minimum 2.
- DISCARD_FRAMES, 1: number of accepted `SYNC` edges dropped after `PLDRESETn` rises.

Ports:
- CLK_24MHZ_FPGA  in  1  sole clock.
- nSYSPOR  in  1  reset, asynchronous, active-low.
- SYNC  in  1  frame marker from the PLDCLK domain; high for one PLDCLK period (≥48 clocks).
- PLDRESETn  in  1  PLD stream mode; low means the static/ID phase, when no ADC data is valid.
- PGOOD  in  1  power-good from the stream; frames seen while it is low are dropped.
- ADCSEL  in  3  channel index of the current frame.
- ADC_DOUTA  in  12  ADC A result.
- ADC_DOUTB  in  12  ADC B result.
- RD_EN  in  1  read strobe.
- RD_ADDR  in  4  {adc (0=A, 1=B), ADCSEL}.
- RD_DATA  out  16  {new, ovr, 2'b00, value[11:0]}.
- RD_VALID  out  1  pulses 1 cycle after `RD_EN`.
- NEWFLAGS  out  16  per-slot new flags.
- FRAME_CNT  out  16  count of accepted frames; wraps.
- SAMPLE_STB  out  1  one-cycle pulse after each slot pair is written.

## Operation
- `SYNC` and `PLDRESETn` each pass through a SYNC_STAGES flop chain. A rising edge of the synchronised `SYNC` is a frame event.
- The ADC buses and `ADCSEL`/`PGOOD` are quasi-static at the frame event: they were last updated at least 6 PLDCLK periods earlier. They are sampled directly, without synchronisers, in the cycle the event is detected.
- FSM states and transitions:
  - WAIT_LOW: wait for synchronised `SYNC`=0, then go to ARMED.
  - ARMED: on a frame event, latch the inputs. If synchronised `PLDRESETn`=1, `PGOOD`=1 and the discard counter is 0, go to WR_A. Otherwise stay in ARMED and, when synchronised `PLDRESETn`=1, decrement the discard counter.
  - WR_A: write the A slot, then go to WR_B.
  - WR_B: write the B slot, pulse SAMPLE_STB, increment FRAME_CNT, then return to ARMED.
- Synchronised `PLDRESETn`=0 in any state: reload the discard counter with DISCARD_FRAMES and go to WAIT_LOW. Stored data is kept.
- Slot write:
  - Store the value.
  - If new=1 beforehand, set ovr; ovr is sticky.
  - Set new=1.
- Read: RD_DATA and RD_VALID are registered from the slot at RD_ADDR.
  - The read clears new and ovr of that slot.
  - If a read and a write hit the same slot in the same cycle, RD_DATA returns the old contents. The write wins: new stays 1, and ovr is set from the pre-write new flag.
- Reset values:
  - All slot values, new and ovr flags: 0.
  - RD_DATA=0, RD_VALID=0, SAMPLE_STB=0, FRAME_CNT=0.
  - FSM in WAIT_LOW; discard counter = DISCARD_FRAMES.

## Timing
- Frame event latency: SYNC_STAGES+1 cycles after the `SYNC` rise reaches the pin.
- The A slot is written 1 cycle after the event and the B slot 1 cycle after that. SAMPLE_STB and FRAME_CNT update in the cycle of the B write.
- Read latency is 1 cycle. Back-to-back `RD_EN` is allowed every cycle.
- A `SYNC` high pulse shorter than SYNC_STAGES+1 cycles may be missed. Only one event is produced per high period.
- Reset asserted mid-write abandons the frame. Reset values apply immediately.

## Configuration
- ADC_AVERAGE_EN defined:
  - Each slot keeps a 14-bit accumulator and a 2-bit sample count.
  - Every frame adds the sample to the accumulator.
  - On the 4th sample, the slot value becomes sum[13:2], new/ovr update as above, and the accumulator and count clear.
  - SAMPLE_STB and FRAME_CNT still count every accepted frame.
  - `PLDRESETn` low clears all accumulators and counts.
- ADC_AVERAGE_EN undefined: every accepted frame publishes the raw sample. No accumulator logic exists.

## Structure
- Package `adc_store_pkg` holds:
  - the FSM state enum;
  - constants NUM_SLOTS=16, VALUE_W=12, RD_W=16 and the RD_DATA bit positions.
- Sub-module `pld_sync2`: parameterised-depth single-bit synchroniser, instantiated for `SYNC` and `PLDRESETn`.

## Test plan
- Reset, then `PLDRESETn`=1, `PGOOD`=1, ADCSEL=3, A=0x5A5, B=0x0F0, two `SYNC` pulses. Expect:
  - the first frame discarded;
  - then slot 3=0x5A5 and slot 11=0x0F0, NEWFLAGS=0x0808, FRAME_CNT=1;
  - read of address 3 returns 0x85A5.
- Two frames to ADCSEL=1 with no read in between, then read address 1: RD_DATA[15:14]=2'b11. A second read returns 2'b00 in [15:14].
- `PGOOD`=0 during a frame: no slot changes, no SAMPLE_STB, FRAME_CNT unchanged.
- `PLDRESETn` pulsed low mid-stream, then high: first subsequent frame dropped, next accepted; stored data unchanged across the low period.
- `RD_EN` at address 8 in the exact WR_B cycle for ADCSEL=0: RD_DATA shows the old value; NEWFLAGS[8] stays 1.
- With ADC_AVERAGE_EN: ADCSEL=2 with A samples 100, 200, 300, 400. Slot 2 stays unchanged for the first three frames, then becomes 250 with new=1.
